register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
- Parametrised multi-port successor to the CPU's 2R/1W register file.
- Configurable data width, register count, read-port count and write-port count.
- Synchronous, registered reads with per-port read enable and hold.
- Same-cycle write-to-read forwarding, deterministic write-port priority, register 0 hardwired to zero.
- Sits in the decode stage; dual-issue and multi-writeback pipelines connect here.

Parameters:
DATA_W, 32, width of each register in bits
NREGS, 32, number of registers; power of two, at least 2
NRD, 2, number of read ports, 1..4
NWR, 1, number of write ports, 1..2
AW, $clog2(NREGS), select width; derived, never overridden

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
ren  in  NRD  per-read-port enable
rsel  in  NRD*AW  read selects; port i occupies bits [i*AW +: AW]
rdat  out  NRD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W]
wen  in  NWR  per-write-port enable
wsel  in  NWR*AW  write selects
wdat  in  NWR*DATA_W  write data
perr  out  NRD  per-read-port parity error flag; present only with the optional feature

Behaviour:
- Reset, asserted asynchronously: every register = 0, every rdat lane = 0, every perr bit = 0. The block stays in reset while nRST is low. Reset mid-operation discards in-flight writes and reads; the first edge after release behaves as a normal edge.
- Register 0: writes to it are ignored; reads of it always return 0, including under forwarding.
- Write: on the rising edge, if wen[j] is high and wsel[j] != 0, the register is loaded with wdat[j].
- Write collision: two ports writing the same register on the same edge; the higher-index port wins.
- Read latency is 1 cycle.
  - If ren[i] is high at edge N, rdat[i] after edge N = value of register rsel[i] with all writes of edge N applied (write-first).
  - Forwarding uses the same collision priority as the write path.
- Read hold: if ren[i] is low, rdat[i] holds its previous value. This holds even when the held register is overwritten.
- Duplicate selects: multiple read ports may select the same register; each returns identical data.
- Out-of-range selects (NREGS not a power of two is illegal): not supported. The verification engineer checks this with an assertion.
- Arithmetic: none; data passes through unmodified.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each register stores one extra even-parity bit, computed from wdat on write.
  - On a read with ren[i] high, perr[i] is registered alongside rdat[i] as stored-data parity XOR stored bit.
  - Forwarded reads recompute parity from wdat, so perr = 0.
  - Register 0 always gives perr = 0.
  - perr holds when ren[i] is low.
  - A test-only input is not added; the bench forces storage via a hierarchical path.
- Undefined: no parity storage; perr is absent from the port list.

Decomposition:
- Shared package (cpu_types_pkg extension):
  - constant REG_ZERO = 0
  - typedef regsel_t sized by AW for the default configuration
  - function even_parity(word)
- Natural sub-module: regfile_fwd_mux. It is combinational, instantiated once per read port, and selects between stored data and the highest-priority matching write, with the zero-register override.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert nRST low mid-cycle → rdat all 0 immediately; after release, reading r5 → 0.
- Basic: write r3 = 0x12345678 at edge 1; ren[0] = 1, rsel[0] = 3 at edge 2 → rdat[0] = 0x12345678 after edge 2.
- Forwarding: at the same edge, wen[0] = 1, wsel[0] = 7, wdat[0] = 0xA5A5A5A5, and ren[1] = 1, rsel[1] = 7 → rdat[1] = 0xA5A5A5A5 after that edge.
- Collision (NWR = 2): both ports write r9, port 0 with 0x1, port 1 with 0x2 → r9 reads 0x2, and a forwarded read the same cycle also gives 0x2.
- Zero register: write r0 = 0xFFFFFFFF with a same-cycle read of r0 → rdat = 0; a later read also gives 0.
- Hold + parity: ren[0] = 0 while r3 is rewritten → rdat[0] unchanged. With REGFILE_PARITY_EN, flip a stored bit of r4 and read it → perr[0] = 1; a clean read of r6 gives perr = 0.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared register-file types and helpers for register_file_mp.
// The parity helper covers words up to 64 bits, so REGFILE_PARITY_EN builds need DATA_W <= 64.
package register_file_mp_pkg;

    localparam int REG_ZERO = 0;

    typedef logic [$clog2(32)-1:0] regsel_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/register_file_mp_fwd_mux.sv
// Per-read-port next-data selector: stored word, or the highest-index matching write.
// A select of register zero always yields zero. Parity check output exists only with REGFILE_PARITY_EN.
module regfile_fwd_mux
    import register_file_mp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NWR    = 1
) (
    input  logic [AW-1:0]         rsel,
    input  logic [DATA_W-1:0]     stored_dat,
`ifdef REGFILE_PARITY_EN
    input  logic                  stored_par,
    output logic                  fwd_perr,
`endif
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    output logic [DATA_W-1:0]     fwd_dat
);

    logic [DATA_W-1:0] dat_s;
    logic              zero_sel_s;

    assign zero_sel_s = (rsel == AW'(REG_ZERO));

    // Later (higher-index) write ports override earlier ones, mirroring the write path.
    always_comb begin
        dat_s = stored_dat;
        for (int j = 0; j < NWR; j++) begin
            dat_s = (wen[j] && (wsel[j*AW +: AW] == rsel)) ? wdat[j*DATA_W +: DATA_W] : dat_s;
        end
        fwd_dat = zero_sel_s ? {DATA_W{1'b0}} : dat_s;
    end

`ifdef REGFILE_PARITY_EN
    logic hit_s;

    // Forwarded data carries freshly computed parity, so only stored reads can flag an error.
    always_comb begin
        hit_s = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            hit_s = hit_s | (wen[j] && (wsel[j*AW +: AW] == rsel));
        end
        fwd_perr = (zero_sel_s || hit_s) ? 1'b0 : (even_parity(64'(stored_dat)) ^ stored_par);
    end
`endif

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file: registered write-first reads, r0 hardwired to zero.
// Optional macro REGFILE_PARITY_EN adds a stored even-parity bit per register and a perr output.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 32,
    parameter  int NRD    = 2,
    parameter  int NWR    = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NRD-1:0]        ren,
    input  logic [NRD*AW-1:0]     rsel,
    output logic [NRD*DATA_W-1:0] rdat,
`ifdef REGFILE_PARITY_EN
    output logic [NRD-1:0]        perr,
`endif
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat
);

    logic [DATA_W-1:0] mem_r     [NREGS];
    logic [DATA_W-1:0] fwd_dat_s [NRD];
`ifdef REGFILE_PARITY_EN
    logic              par_r      [NREGS];
    logic              fwd_perr_s [NRD];
`endif

    // Register array; the last matching write port in the loop wins a collision.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < NREGS; k++) begin
                mem_r[k] <= {DATA_W{1'b0}};
`ifdef REGFILE_PARITY_EN
                par_r[k] <= 1'b0;
`endif
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (wsel[j*AW +: AW] != AW'(REG_ZERO))) begin
                    mem_r[wsel[j*AW +: AW]] <= wdat[j*DATA_W +: DATA_W];
`ifdef REGFILE_PARITY_EN
                    par_r[wsel[j*AW +: AW]] <= even_parity(64'(wdat[j*DATA_W +: DATA_W]));
`endif
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_fwd_mux #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .NWR    (NWR)
        ) u_fwd_mux (
            .rsel       (rsel[i*AW +: AW]),
            .stored_dat (mem_r[rsel[i*AW +: AW]]),
`ifdef REGFILE_PARITY_EN
            .stored_par (par_r[rsel[i*AW +: AW]]),
            .fwd_perr   (fwd_perr_s[i]),
`endif
            .wen        (wen),
            .wsel       (wsel),
            .wdat       (wdat),
            .fwd_dat    (fwd_dat_s[i])
        );
    end

    // Read lanes capture only when enabled and otherwise hold, even if the source changes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rdat <= {(NRD*DATA_W){1'b0}};
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (ren[i]) begin
                    rdat[i*DATA_W +: DATA_W] <= fwd_dat_s[i];
                end
            end
        end
    end

`ifdef REGFILE_PARITY_EN
    // Parity flags follow the same capture/hold rule as their data lanes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perr <= {NRD{1'b0}};
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (ren[i]) begin
                    perr[i] <= fwd_perr_s[i];
                end
            end
        end
    end
`endif

endmodule
